// File: rtl/inst_line_server_pkg.sv
// inst_line_server_pkg
//   Shared constants and state encoding for the instruction line server.
//   True_v/False_v/ZeroWord are the common codebase constants; LineBytes is
//   the fixed refill line size in bytes.
package inst_line_server_pkg;

  localparam logic        True_v    = 1'b1;
  localparam logic        False_v   = 1'b0;
  localparam logic [31:0] ZeroWord  = 32'h0000_0000;
  localparam int          LineBytes = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_COOL  = 2'd2
  } line_state_e;

endpackage

// File: rtl/inst_line_server.sv
// inst_line_server
//   Memory-side responder for the instruction-fetch line refill. A request
//   latches a 16-byte aligned base, then sixteen byte reads are issued on the
//   byte-wide RAM port (one per granted, ready cycle) and the returned bytes
//   are assembled little-endian into ram_inst.
// Ports
//   clk, rst        clock, synchronous active-high reset
//   rdy             chip ready; low freezes everything but an in-flight capture
//   ram_inst_re     line request (level, held until busy is seen low)
//   ram_inst_addr   request address, low nibble ignored
//   ram_inst        assembled line, byte k in [8k+7:8k]
//   ram_inst_busy   high while a fetch is in progress
//   mem_gnt         arbiter grant for the RAM port this cycle
//   mem_din         RAM read data, valid the cycle after mem_rd_en
//   mem_a           RAM byte address
//   mem_rd_en       read issued this cycle
module inst_line_server
  import inst_line_server_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         rdy,
  input  logic         ram_inst_re,
  input  logic [31:0]  ram_inst_addr,
  output logic [127:0] ram_inst,
  output logic         ram_inst_busy,
  input  logic         mem_gnt,
  input  logic [7:0]   mem_din,
  output logic [31:0]  mem_a,
  output logic         mem_rd_en
);

  line_state_e state, state_nxt;
  logic [31:0] base;
  logic [4:0]  issue_cnt;
  logic [4:0]  cap_cnt;
  logic        cap_vld;
  logic        accept;
  logic        last_cap;

  assign accept   = (state == ST_IDLE) && rdy && ram_inst_re;
  assign last_cap = (state == ST_FETCH) && cap_vld && (cap_cnt == 5'(LineBytes - 1));

  assign mem_rd_en = (state == ST_FETCH) && rdy && mem_gnt
                     && (issue_cnt < 5'(LineBytes));

  // base is 16-byte aligned, so the offset is spliced into the low nibble:
  // the line can never carry into bit 4. Once all 16 are issued the nibble
  // is 0 again and mem_a falls back to base.
  assign mem_a = (state == ST_FETCH) ? {base[31:4], issue_cnt[3:0]} : base;

  assign ram_inst_busy = (state == ST_FETCH) ? True_v : False_v;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // The FETCH exit rides on the last capture, which is not rdy-gated, so the
  // line completes even if rdy drops while byte 15 is in flight. COOL holds
  // for one ready cycle so a still-high re is not re-accepted.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (accept)   state_nxt = ST_FETCH;
      ST_FETCH: if (last_cap) state_nxt = ST_COOL;
      ST_COOL:  if (rdy)      state_nxt = ST_IDLE;
      default:                state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      base      <= ZeroWord;
      issue_cnt <= '0;
      cap_cnt   <= '0;
      cap_vld   <= False_v;
      ram_inst  <= '0;
    end else begin
      // One-cycle RAM latency: what was issued now is captured next cycle.
      cap_vld <= mem_rd_en;
      if (accept) begin
        base      <= {ram_inst_addr[31:4], 4'h0};
        issue_cnt <= '0;
        cap_cnt   <= '0;
      end else begin
        if (mem_rd_en) issue_cnt <= issue_cnt + 5'd1;
        if (cap_vld) begin
          ram_inst[{cap_cnt[3:0], 3'b000} +: 8] <= mem_din;
          cap_cnt <= cap_cnt + 5'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_inst_line_server.sv
// tb_inst_line_server
//   Directed bench for inst_line_server. The RAM model answers a read of
//   address a with (a & 0xFF) + 0x10 one cycle later; every expected line is
//   written out as a hand-computed constant.
module tb_inst_line_server;

  logic         clk = 1'b0;
  logic         rst, rdy, ram_inst_re, mem_gnt;
  logic [31:0]  ram_inst_addr, mem_a;
  logic [127:0] ram_inst;
  logic         ram_inst_busy, mem_rd_en;
  logic [7:0]   mem_din;
  int           n_chk = 0;
  int           n_err = 0;

  always #5 clk = ~clk;

  inst_line_server dut (
    .clk          (clk),
    .rst          (rst),
    .rdy          (rdy),
    .ram_inst_re  (ram_inst_re),
    .ram_inst_addr(ram_inst_addr),
    .ram_inst     (ram_inst),
    .ram_inst_busy(ram_inst_busy),
    .mem_gnt      (mem_gnt),
    .mem_din      (mem_din),
    .mem_a        (mem_a),
    .mem_rd_en    (mem_rd_en)
  );

  always @(posedge clk) if (mem_rd_en) mem_din <= mem_a[7:0] + 8'h10;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Runs one fetch. Cycle c counts from the accept edge (cycle 1 = first busy
  // cycle). mem_gnt is low in cycles gs..gs+gn-1, rdy low in rs..rs+rn-1.
  task automatic do_fetch(input logic [31:0] addr, input int gs, input int gn,
                          input int rs, input int rn, input int exp_busy,
                          input logic [127:0] exp_line);
    logic [31:0] b;
    int c, busy_n, rd_n;
    bit addr_bad, done;
    b = {addr[31:4], 4'h0};
    c = 0; busy_n = 0; rd_n = 0; addr_bad = 0; done = 0;
    ram_inst_re = 1'b1; ram_inst_addr = addr;
    while (!done && c < 60) begin
      @(posedge clk); #1; c++;
      mem_gnt = !(c >= gs && c < gs + gn);
      rdy     = !(c >= rs && c < rs + rn);
      @(negedge clk);
      if (c == 1) chk("busy_rise", 128'(ram_inst_busy), 128'(1));
      if (!mem_gnt && ram_inst_busy) begin
        chk("gap_hold_a", 128'(mem_a), 128'(b + 32'(rd_n)));
        chk("gap_no_rd", 128'(mem_rd_en), 128'(0));
      end
      if (mem_rd_en) begin
        if (mem_a !== b + 32'(rd_n)) addr_bad = 1;
        rd_n++;
      end
      if (ram_inst_busy) busy_n++;
      else if (c > 1) done = 1;
    end
    chk("fetch_done", 128'(done), 128'(1));
    chk("busy_cycles", 128'(busy_n), 128'(exp_busy));
    chk("rd_pulses", 128'(rd_n), 128'(16));
    chk("addr_seq_bad", 128'(addr_bad), 128'(0));
    chk("line", ram_inst, exp_line);
    // re was still high on the COOL edge; it must not start a second fetch
    @(posedge clk); #1;
    ram_inst_re = 1'b0; mem_gnt = 1'b1; rdy = 1'b1;
    @(negedge clk);
    chk("cool_ignores_re", 128'(ram_inst_busy), 128'(0));
    chk("idle_no_rd", 128'(mem_rd_en), 128'(0));
    chk("idle_mem_a", 128'(mem_a), 128'(b));
    chk("line_held", ram_inst, exp_line);
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; ram_inst_re = 1'b0; ram_inst_addr = '0; mem_gnt = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 128'(ram_inst_busy), 128'(0));
    chk("rst_line", ram_inst, 128'(0));
    chk("rst_rd_en", 128'(mem_rd_en), 128'(0));
    chk("rst_mem_a", 128'(mem_a), 128'(0));
    @(posedge clk); #1; rst = 1'b0;

    // basic fetch
    do_fetch(32'h0000_1234, 0, 0, 0, 0, 17, 128'h4F4E4D4C4B4A49484746454443424140);
    // re-assert two cycles later at another line
    idle(2);
    do_fetch(32'h0000_2000, 0, 0, 0, 0, 17, 128'h1F1E1D1C1B1A19181716151413121110);
    // grant gap cycles 5..7
    idle(2);
    do_fetch(32'h0000_1234, 5, 3, 0, 0, 20, 128'h4F4E4D4C4B4A49484746454443424140);
    // rdy low cycles 6..8, byte 4 in flight when it drops
    idle(2);
    do_fetch(32'h0000_3050, 0, 0, 6, 3, 20, 128'h6F6E6D6C6B6A69686766656463626160);
    // top of memory, no wrap
    idle(2);
    do_fetch(32'hFFFF_FFFC, 0, 0, 0, 0, 17, 128'h0F0E0D0C0B0A09080706050403020100);

    // reset in cycle 8 of a fetch
    idle(2);
    ram_inst_re = 1'b1; ram_inst_addr = 32'h0000_1000;
    idle(8);
    chk("mid_busy", 128'(ram_inst_busy), 128'(1));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; ram_inst_re = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", 128'(ram_inst_busy), 128'(0));
    chk("mid_rst_rd_en", 128'(mem_rd_en), 128'(0));
    chk("mid_rst_line", ram_inst, 128'(0));
    chk("mid_rst_mem_a", 128'(mem_a), 128'(0));
    idle(1);
    do_fetch(32'h0000_0040, 0, 0, 0, 0, 17, 128'h5F5E5D5C5B5A59585756555453525150);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
